// File: rtl/uart_pkg.sv
// Shared types and line-level constants for the buffered UART transmitter.
// UART_TX_PARITY_EN adds the PARITY state (even parity, 11-bit frame).
package uart_pkg;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} tx_state_t;
`endif

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with show-ahead read data and an occupancy count.
// DEPTH must be a power of two so the pointers wrap on natural overflow.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 full,
    output logic                 empty,
    output logic [LVL_W-1:0]     level
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    // a pop in the same cycle never frees room for a push into a full FIFO
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// UART transmitter fed by a byte FIFO; frames go out back-to-back while queued.
// UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | driving the start bit
// DATA   | shifting out 8 data bits, LSB first
// PARITY | driving even parity of the byte (UART_TX_PARITY_EN only)
// STOP   | driving the stop bit; pops the next byte at its end
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [DATA_BITS-1:0]        wr_data,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    output logic                        TxD,
    output logic                        busy,
    output logic                        TxD_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_TC = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t            state;
    logic [CNT_W-1:0]     baud_cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] fifo_rd_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 bit_end;
    logic                 load_frame;
`ifdef UART_TX_PARITY_EN
    logic                 parity_bit;
`endif

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (wr_valid),
        .pop     (load_frame),
        .wr_data (wr_data),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign wr_ready   = !fifo_full;
    // baud_cnt is held at zero in IDLE, so bit_end is also the idle condition
    assign bit_end    = (baud_cnt == '0);
    assign load_frame = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            TxD       <= STOP_BIT;
            busy      <= 1'b0;
            TxD_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            TxD_done <= (state == STOP) && bit_end;
            if (load_frame) begin
                state     <= START;
                shift_reg <= fifo_rd_data;
                TxD       <= START_BIT;
                baud_cnt  <= BIT_TC;
                bit_idx   <= '0;
                busy      <= 1'b1;
`ifdef UART_TX_PARITY_EN
                parity_bit <= ^fifo_rd_data;
`endif
            end else if (!bit_end) begin
                baud_cnt <= baud_cnt - CNT_W'(1);
            end else begin
                baud_cnt <= BIT_TC;
                case (state)
                    START: begin
                        state     <= DATA;
                        TxD       <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                    end
                    DATA: begin
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            TxD   <= parity_bit;
`else
                            state <= STOP;
                            TxD   <= STOP_BIT;
`endif
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            TxD       <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        state <= STOP;
                        TxD   <= STOP_BIT;
                    end
`endif
                    STOP: begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        baud_cnt <= '0;
                    end
                    default: begin
                        state    <= IDLE;
                        baud_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule
